input_current_accumulator: RTL and testbench

- Parametrised successor of the single-cycle input-current calculator.
- Time-multiplexed: sums weights of active input spikes over ceil(M/LANES) cycles, LANES synapses per cycle, using a start/busy/done handshake.
- Supports signed or unsigned weights of configurable width and saturates the result to an OW-bit signed input current with a saturation flag.
- Sits between the spike/delay stage and the neuron membrane update in each SNN neuron.

---
 rtl/snn_pkg.sv | 46 ++++
 rtl/input_current_accumulator_if.sv | 24 ++
 rtl/lane_adder_tree.sv | 29 ++
 rtl/input_current_accumulator.sv | 124 ++++++++++++
 tb/tb_input_current_accumulator.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared SNN helpers: default widths, ceil-log2, and signed saturation to an
// arbitrary output width.
package snn_pkg;

    localparam int WW_DEF = 8;
    localparam int OW_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r++;
        end
        return r;
    endfunction

    // Clamp a wide signed value into the two's complement range of ow bits.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int ow,
                                                    output logic sat);
        logic signed [63:0] omax;
        logic signed [63:0] omin;
        logic signed [63:0] res;
        omax = (64'sd1 <<< (ow - 1)) - 64'sd1;
        omin = -(64'sd1 <<< (ow - 1));
        sat  = 1'b0;
        res  = v;
        if (v > omax) begin
            res = omax;
            sat = 1'b1;
        end else if (v < omin) begin
            res = omin;
            sat = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/input_current_accumulator_if.sv
// Start/busy/done handshake and data bus of the input-current accumulator.
interface input_current_accumulator_if #(
    parameter int M  = 24,
    parameter int WW = 8,
    parameter int OW = 8
);
    logic             start;
    logic [M-1:0]     input_spikes;
    logic [M*WW-1:0]  weights;
    logic             busy;
    logic             done;
    logic [OW-1:0]    input_current;
    logic             saturated;

    modport master (
        output start, input_spikes, weights,
        input  busy, done, input_current, saturated
    );

    modport slave (
        input  start, input_spikes, weights,
        output busy, done, input_current, saturated
    );
endinterface

// File: rtl/lane_adder_tree.sv
// Combinational sum of one chunk: each lane adds its extended weight when its
// spike bit is set.
module lane_adder_tree #(
    parameter int LANES    = 4,
    parameter int WW       = 8,
    parameter int ACC_W    = 14,
    parameter bit SIGNED_W = 1'b1
) (
    input  logic [LANES-1:0]          spikes,
    input  logic [LANES-1:0][WW-1:0]  weights,
    output logic signed [ACC_W-1:0]   partial
);

    logic signed [ACC_W-1:0] term [LANES];

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic sx;
        assign sx      = SIGNED_W ? weights[j][WW-1] : 1'b0;
        assign term[j] = spikes[j] ? {{(ACC_W-WW){sx}}, weights[j]} : '0;
    end

    always_comb begin
        partial = '0;
        for (int j = 0; j < LANES; j++) begin
            partial = partial + term[j];
        end
    end

endmodule

// File: rtl/input_current_accumulator.sv
// Time-multiplexed input-current accumulator: sums LANES synapses per cycle
// over ceil(M/LANES) cycles, then saturates into an OW-bit signed current.
module input_current_accumulator
    import snn_pkg::*;
#(
    parameter int M        = 24,
    parameter int LANES    = 4,
    parameter int WW       = WW_DEF,
    parameter int OW       = OW_DEF,
    parameter bit SIGNED_W = 1'b1
) (
    input logic                          clk,
    input logic                          reset,
    input_current_accumulator_if.slave   bus
);

    localparam int NCHUNK = (M + LANES - 1) / LANES;
    localparam int ACC_W  = WW + clog2(M) + 1;
    localparam int IDX_W  = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
    localparam int NPAD   = NCHUNK * LANES;

    acc_state_t              state, state_nx;
    logic [IDX_W-1:0]        idx, idx_nx;
    logic signed [ACC_W-1:0] acc, acc_nx;
    logic [M-1:0]            spk_lat, spk_nx;
    logic                    done_r, done_nx;
    logic [OW-1:0]           cur, cur_nx;
    logic                    sat_r, sat_nx;

    // Pad to a whole number of chunks so the tail lanes read zeros.
    logic [NPAD-1:0]         spk_pad;
    logic [NPAD-1:0][WW-1:0] w_pad;
    logic [LANES-1:0]          lane_spk;
    logic [LANES-1:0][WW-1:0]  lane_w;
    logic signed [ACC_W-1:0] partial;
    logic signed [ACC_W-1:0] sum;
    logic signed [63:0]      sat_val;
    logic                    sat_flag;
    logic                    unused_hi;

    always_comb begin
        spk_pad = '0;
        w_pad   = '0;
        for (int i = 0; i < M; i++) begin
            spk_pad[i] = spk_lat[i];
            w_pad[i]   = bus.weights[i*WW +: WW];
        end
    end

    assign lane_spk = spk_pad[int'(idx)*LANES +: LANES];
    assign lane_w   = w_pad[int'(idx)*LANES +: LANES];

    lane_adder_tree #(
        .LANES    (LANES),
        .WW       (WW),
        .ACC_W    (ACC_W),
        .SIGNED_W (SIGNED_W)
    ) u_tree (
        .spikes  (lane_spk),
        .weights (lane_w),
        .partial (partial)
    );

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        acc_nx    = acc;
        spk_nx    = spk_lat;
        done_nx   = 1'b0;
        cur_nx    = cur;
        sat_nx    = sat_r;
        sum       = acc + partial;
        sat_val   = saturate(64'(sum), OW, sat_flag);
        unused_hi = ^sat_val[63:OW];
        case (state)
            IDLE: begin
                if (bus.start) begin
                    spk_nx   = bus.input_spikes;
                    acc_nx   = '0;
                    idx_nx   = '0;
                    state_nx = ACCUM;
                end
            end
            ACCUM: begin
                if (idx == IDX_W'(NCHUNK - 1)) begin
                    cur_nx   = sat_val[OW-1:0];
                    sat_nx   = sat_flag;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    acc_nx = sum;
                    idx_nx = idx + IDX_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            acc     <= '0;
            spk_lat <= '0;
            done_r  <= 1'b0;
            cur     <= '0;
            sat_r   <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            acc     <= acc_nx;
            spk_lat <= spk_nx;
            done_r  <= done_nx;
            cur     <= cur_nx;
            sat_r   <= sat_nx;
        end
    end

    assign bus.busy          = (state == ACCUM);
    assign bus.done          = done_r;
    assign bus.input_current = cur;
    assign bus.saturated     = sat_r;

endmodule

// File: tb/tb_input_current_accumulator.sv
// Directed plus randomized checks of the accumulator against a plain-arithmetic
// model, on signed/unsigned M=24 instances and an M=6 partial-chunk instance.
module tb_input_current_accumulator;

    logic clk;
    logic reset;
    int   n_tot;
    int   n_pass;

    input_current_accumulator_if #(.M(24), .WW(8), .OW(8)) ifa ();
    input_current_accumulator_if #(.M(24), .WW(8), .OW(8)) ifb ();
    input_current_accumulator_if #(.M(6),  .WW(8), .OW(8)) ifc ();

    input_current_accumulator #(.M(24), .LANES(4), .WW(8), .OW(8), .SIGNED_W(1'b1))
        dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    input_current_accumulator #(.M(24), .LANES(4), .WW(8), .OW(8), .SIGNED_W(1'b0))
        dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
    input_current_accumulator #(.M(6), .LANES(4), .WW(8), .OW(8), .SIGNED_W(1'b1))
        dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

    // The unsigned instance sees exactly the signed instance's stimulus.
    assign ifb.start        = ifa.start;
    assign ifb.input_spikes = ifa.input_spikes;
    assign ifb.weights      = ifa.weights;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [23:0] sp_a;
    logic [7:0]  wa [24];
    logic [5:0]  sp_c;
    logic [7:0]  wc [24];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int n, input bit sgn, input logic [23:0] sp,
                                  input logic [7:0] w [24],
                                  output logic [7:0] ic, output logic sat);
        int s;
        s = 0;
        for (int i = 0; i < n; i++)
            if (sp[i]) s += sgn ? int'($signed(w[i])) : int'(w[i]);
        sat = (s > 127) || (s < -128);
        if (s > 127) s = 127;
        else if (s < -128) s = -128;
        ic = s[7:0];
    endfunction

    // Entered at a negedge; starts a request and follows it to done.
    task automatic run_ab(input string tag, input bit glitch, input bit b2b);
        logic [23:0] sp0;
        logic [7:0]  ea, eb;
        logic        sa, sb;
        int          cyc, nbusy;
        sp0 = sp_a;
        model(24, 1'b1, sp0, wa, ea, sa);
        model(24, 1'b0, sp0, wa, eb, sb);
        ifa.input_spikes = sp0;
        for (int i = 0; i < 24; i++) ifa.weights[i*8 +: 8] = wa[i];
        ifa.start = 1'b1;
        @(negedge clk);
        cyc = 0;
        nbusy = 0;
        while (ifa.done !== 1'b1 && cyc < 20) begin
            if (ifa.busy === 1'b1) nbusy++;
            if (glitch && cyc == 2) begin
                ifa.start = 1'b1;
                ifa.input_spikes = ~sp0;
            end else begin
                ifa.start = 1'b0;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        ifa.start = 1'b0;
        check({tag, "/latency"}, cyc, 6);
        check({tag, "/busy_cycles"}, nbusy, 6);
        check({tag, "/busy_low"}, ifa.busy, 0);
        check({tag, "/a_current"}, ifa.input_current, ea);
        check({tag, "/a_sat"}, ifa.saturated, sa);
        check({tag, "/b_done"}, ifb.done, 1);
        check({tag, "/b_current"}, ifb.input_current, eb);
        check({tag, "/b_sat"}, ifb.saturated, sb);
        if (!b2b) begin
            @(negedge clk);
            check({tag, "/done_pulse"}, ifa.done, 0);
        end
    endtask

    task automatic run_c(input string tag, input bit b2b);
        logic [7:0] ec;
        logic       sc;
        int         cyc;
        model(6, 1'b1, 24'(sp_c), wc, ec, sc);
        ifc.input_spikes = sp_c;
        for (int i = 0; i < 6; i++) ifc.weights[i*8 +: 8] = wc[i];
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        cyc = 0;
        while (ifc.done !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check({tag, "/latency"}, cyc, 2);
        check({tag, "/current"}, ifc.input_current, ec);
        check({tag, "/sat"}, ifc.saturated, sc);
        if (!b2b) begin
            @(negedge clk);
            check({tag, "/done_pulse"}, ifc.done, 0);
        end
    endtask

    initial begin
        int ndone;
        n_tot = 0;
        n_pass = 0;
        reset = 1'b1;
        ifa.start = 1'b0;
        ifa.input_spikes = '0;
        ifa.weights = '0;
        ifc.start = 1'b0;
        ifc.input_spikes = '0;
        ifc.weights = '0;
        for (int i = 0; i < 24; i++) begin
            wa[i] = 8'd0;
            wc[i] = 8'd0;
        end
        repeat (3) @(negedge clk);
        check("reset/busy", ifa.busy, 0);
        check("reset/done", ifa.done, 0);
        check("reset/current", ifa.input_current, 0);
        check("reset/sat", ifa.saturated, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 24; i++) wa[i] = 8'd10;
        sp_a = 24'h00000F;
        run_ab("sum40", 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) wa[i] = 8'd100;
        sp_a = 24'hFFFFFF;
        run_ab("pos_clamp", 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) wa[i] = 8'hF6;
        run_ab("neg_clamp", 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) wa[i] = 8'($urandom);
        wa[0] = 8'hFF;
        sp_a = 24'h000001;
        run_ab("unsigned_ff", 1'b0, 1'b0);

        // Abort in the third accumulation cycle; the last result was nonzero.
        for (int i = 0; i < 24; i++) wa[i] = 8'd1;
        ifa.input_spikes = 24'hFFFFFF;
        for (int i = 0; i < 24; i++) ifa.weights[i*8 +: 8] = wa[i];
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort/busy", ifa.busy, 0);
        check("abort/done", ifa.done, 0);
        check("abort/current", ifa.input_current, 0);
        check("abort/sat", ifa.saturated, 0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (ifa.done === 1'b1) ndone++;
        end
        check("abort/no_done", ndone, 0);
        sp_a = 24'h0000FF;
        run_ab("after_reset", 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) wa[i] = 8'($urandom);
        sp_a = 24'($urandom);
        run_ab("glitch", 1'b1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 24; i++) wa[i] = 8'($urandom);
            sp_a = 24'($urandom);
            run_ab($sformatf("rand_ab%0d", k), 1'b0, k[0]);
        end
        @(negedge clk);

        for (int i = 0; i < 6; i++) wc[i] = 8'(i + 1);
        sp_c = 6'b110000;
        run_c("partial11", 1'b1);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 6; i++) wc[i] = 8'($urandom);
            sp_c = 6'($urandom);
            run_c($sformatf("rand_c%0d", k), k[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
